flow_ctrl_fsm: RTL and testbench

Parametrised flow-control state machine that sits beside the FIFO bank of the switch datapath. It watches the status flags of `NUM_FIFO` FIFOs and issues per-channel pause/continue commands to `NUM_IN` upstream sources. It adds three things: a configurable minimum pause time, an optional per-channel (rather than global) pause mode, and a sticky record of which FIFO overflowed. It also counts pause events for debug.

---
 rtl/flow_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 23 ++
 rtl/flow_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_flow_ctrl_fsm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the FIFO-bank flow-control FSM:
// state encodings and default parameter values.
package flow_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_FIFO    = 5;
    localparam int unsigned DEF_NUM_IN      = 4;
    localparam int unsigned DEF_MIN_PAUSE   = 2;
    localparam bit          DEF_PER_CHANNEL = 1'b0;
    localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous clear.
module sat_counter #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control FSM beside the switch FIFO bank: pauses upstream sources on
// almost-full, latches overflow sources, and counts pause events.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FIFO    = DEF_NUM_FIFO,
    parameter int unsigned NUM_IN      = DEF_NUM_IN,
    parameter int unsigned MIN_PAUSE   = DEF_MIN_PAUSE,
    parameter bit          PER_CHANNEL = DEF_PER_CHANNEL,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                clear_error,
    input  logic [NUM_FIFO-1:0] almost_full,
    input  logic [NUM_FIFO-1:0] full,
    input  logic [NUM_FIFO-1:0] almost_empty,
    input  logic [NUM_FIFO-1:0] empty,
    output logic [NUM_IN-1:0]   continuar,
    output logic [NUM_IN-1:0]   pausa,
    output logic                error_full,
    output logic [NUM_FIFO-1:0] error_src,
    output logic                idle,
    output logic [STATE_W-1:0]  estado,
    output logic [CNT_W-1:0]    pause_cnt
);

    localparam int unsigned       HOLD_W   = (MIN_PAUSE > 1) ? $clog2(MIN_PAUSE) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_PAUSE - 1);

    state_t              state, next_state;
    logic                any_f, any_af, all_e, ds_af;
    logic [HOLD_W-1:0]   hold_q;
    logic                hold_clr, hold_inc, pause_inc;
    logic [NUM_IN-1:0]   cont_d, pausa_d;
    logic                err_d, idle_d;
    logic [NUM_FIFO-1:0] src_d;
    logic                unused_flags;

    assign any_f        = |full;
    assign any_af       = |almost_full;
    assign all_e        = &empty;
    assign unused_flags = ^almost_empty;

    // Downstream almost-full; stays 0 when every FIFO is an upstream one.
    always_comb begin
        ds_af = 1'b0;
        for (int unsigned i = NUM_IN; i < NUM_FIFO; i++) begin
            ds_af = ds_af | almost_full[i];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:   if (iniciar) next_state = ST_IDLE;
            ST_IDLE: begin
                if (any_f)       next_state = ST_ERROR;
                else if (!all_e) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_f)       next_state = ST_ERROR;
                else if (any_af) next_state = ST_PAUSE;
                else if (all_e)  next_state = ST_IDLE;
            end
            ST_PAUSE: begin
                if (any_f)                              next_state = ST_ERROR;
                else if ((hold_q == HOLD_MAX) && !any_af) next_state = ST_ACTIVE;
            end
            ST_ERROR:  if (clear_error) next_state = ST_INIT;
            default:   next_state = ST_INIT;
        endcase
    end

    assign hold_clr  = (next_state == ST_PAUSE) && (state != ST_PAUSE);
    assign hold_inc  = (next_state == ST_PAUSE) && (state == ST_PAUSE);
    assign pause_inc = (next_state == ST_PAUSE) && (state == ST_ACTIVE);

    sat_counter #(
        .WIDTH (HOLD_W),
        .MAX   (HOLD_MAX)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .q     (hold_q)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_pause_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (pause_inc),
        .q     (pause_cnt)
    );

    // Outputs are decoded from next_state so they line up with the state register.
    always_comb begin
        cont_d  = '0;
        pausa_d = '0;
        err_d   = 1'b0;
        idle_d  = 1'b0;
        src_d   = '0;
        case (next_state)
            ST_IDLE: begin
                idle_d = 1'b1;
                cont_d = '1;
            end
            ST_ACTIVE: cont_d = '1;
            ST_PAUSE: begin
                if (PER_CHANNEL) begin
                    pausa_d = almost_full[NUM_IN-1:0] | {NUM_IN{ds_af}};
                    cont_d  = ~pausa_d;
                end else begin
                    pausa_d = '1;
                end
            end
            ST_ERROR: begin
                err_d   = 1'b1;
                pausa_d = '1;
                src_d   = (state == ST_ERROR) ? error_src : full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_INIT;
            continuar  <= '0;
            pausa      <= '0;
            error_full <= 1'b0;
            error_src  <= '0;
            idle       <= 1'b0;
        end else begin
            state      <= next_state;
            continuar  <= cont_d;
            pausa      <= pausa_d;
            error_full <= err_d;
            error_src  <= src_d;
            idle       <= idle_d;
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Scoreboard bench: global, per-channel and narrow-counter variants share one stimulus stream.
module tb_flow_ctrl_fsm;

    localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_ACT = 3'd2, S_PAUSE = 3'd3, S_ERR = 3'd4;

    logic       clk = 1'b0;
    logic       reset, iniciar, clear_error;
    logic [4:0] almost_full, full, almost_empty, empty;

    logic [3:0] cont_g, pau_g, cont_p, pau_p, cont_s, pau_s;
    logic       err_g, err_p, err_s, idle_g, idle_p, idle_s;
    logic [4:0] src_g, src_p, src_s;
    logic [2:0] st_g, st_p, st_s;
    logic [7:0] cnt_g, cnt_p;
    logic [1:0] cnt_s;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [3:0] cont_g, pau_g, cont_p, pau_p;
        logic       err, idl;
        logic [4:0] src;
        logic [7:0] cnt;
        logic [1:0] cnt_s;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [2:0] m_prev = S_INIT;
    int         m_cnt  = 0;
    logic [4:0] m_src  = '0;

    always #5 clk = ~clk;

    flow_ctrl_fsm #(.NUM_FIFO(5), .NUM_IN(4), .MIN_PAUSE(2), .PER_CHANNEL(1'b0), .CNT_W(8)) u_glb (
        .clk(clk), .reset(reset), .iniciar(iniciar), .clear_error(clear_error),
        .almost_full(almost_full), .full(full), .almost_empty(almost_empty), .empty(empty),
        .continuar(cont_g), .pausa(pau_g), .error_full(err_g), .error_src(src_g),
        .idle(idle_g), .estado(st_g), .pause_cnt(cnt_g));

    flow_ctrl_fsm #(.NUM_FIFO(5), .NUM_IN(4), .MIN_PAUSE(2), .PER_CHANNEL(1'b1), .CNT_W(8)) u_pch (
        .clk(clk), .reset(reset), .iniciar(iniciar), .clear_error(clear_error),
        .almost_full(almost_full), .full(full), .almost_empty(almost_empty), .empty(empty),
        .continuar(cont_p), .pausa(pau_p), .error_full(err_p), .error_src(src_p),
        .idle(idle_p), .estado(st_p), .pause_cnt(cnt_p));

    flow_ctrl_fsm #(.NUM_FIFO(5), .NUM_IN(4), .MIN_PAUSE(2), .PER_CHANNEL(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .iniciar(iniciar), .clear_error(clear_error),
        .almost_full(almost_full), .full(full), .almost_empty(almost_empty), .empty(empty),
        .continuar(cont_s), .pausa(pau_s), .error_full(err_s), .error_src(src_s),
        .idle(idle_s), .estado(st_s), .pause_cnt(cnt_s));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what every variant must show after the next edge.
    task automatic step(input string tag, input logic rst_v, input logic ini_v, input logic clr_v,
                        input logic [4:0] af_v, input logic [4:0] f_v, input logic [4:0] e_v,
                        input logic [2:0] st_v);
        exp_t       e;
        logic [3:0] pc_pau;
        @(negedge clk);
        reset        = rst_v;
        iniciar      = ini_v;
        clear_error  = clr_v;
        almost_full  = af_v;
        full         = f_v;
        empty        = e_v;
        almost_empty = ~e_v;
        if (!rst_v) begin
            m_cnt = 0;
            m_src = '0;
        end else begin
            if (m_prev == S_ACT && st_v == S_PAUSE) m_cnt++;
            if (st_v == S_ERR) begin
                if (m_prev != S_ERR) m_src = f_v;
            end else begin
                m_src = '0;
            end
        end
        m_prev  = st_v;
        pc_pau  = af_v[3:0] | {4{af_v[4]}};
        e.tag   = tag;
        e.st    = st_v;
        e.err   = (st_v == S_ERR);
        e.idl   = (st_v == S_IDLE);
        e.src   = m_src;
        e.cnt   = (m_cnt > 255) ? 8'hFF : 8'(m_cnt);
        e.cnt_s = (m_cnt > 3) ? 2'h3 : 2'(m_cnt);
        case (st_v)
            S_IDLE, S_ACT: begin e.cont_g = 4'hF; e.pau_g = 4'h0; e.cont_p = 4'hF; e.pau_p = 4'h0; end
            S_PAUSE:       begin e.cont_g = 4'h0; e.pau_g = 4'hF; e.cont_p = ~pc_pau; e.pau_p = pc_pau; end
            S_ERR:         begin e.cont_g = 4'h0; e.pau_g = 4'hF; e.cont_p = 4'h0; e.pau_p = 4'hF; end
            default:       begin e.cont_g = 4'h0; e.pau_g = 4'h0; e.cont_p = 4'h0; e.pau_p = 4'h0; end
        endcase
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, "/estado_g"}, 32'(st_g), 32'(e.st));
                check({e.tag, "/estado_p"}, 32'(st_p), 32'(e.st));
                check({e.tag, "/estado_s"}, 32'(st_s), 32'(e.st));
                check({e.tag, "/cont_g"}, 32'(cont_g), 32'(e.cont_g));
                check({e.tag, "/pausa_g"}, 32'(pau_g), 32'(e.pau_g));
                check({e.tag, "/cont_p"}, 32'(cont_p), 32'(e.cont_p));
                check({e.tag, "/pausa_p"}, 32'(pau_p), 32'(e.pau_p));
                check({e.tag, "/pausa_s"}, 32'(pau_s), 32'(e.pau_g));
                check({e.tag, "/excl_g"}, 32'(cont_g & pau_g), 32'd0);
                check({e.tag, "/excl_p"}, 32'(cont_p & pau_p), 32'd0);
                check({e.tag, "/err_g"}, 32'(err_g), 32'(e.err));
                check({e.tag, "/err_p"}, 32'(err_p), 32'(e.err));
                check({e.tag, "/src_g"}, 32'(src_g), 32'(e.src));
                check({e.tag, "/src_s"}, 32'(src_s), 32'(e.src));
                check({e.tag, "/idle_g"}, 32'(idle_g), 32'(e.idl));
                check({e.tag, "/idle_p"}, 32'(idle_p), 32'(e.idl));
                check({e.tag, "/cnt_g"}, 32'(cnt_g), 32'(e.cnt));
                check({e.tag, "/cnt_p"}, 32'(cnt_p), 32'(e.cnt));
                check({e.tag, "/cnt_s"}, 32'(cnt_s), 32'(e.cnt_s));
            end
        end
    end

    initial begin
        reset = 1'b0; iniciar = 1'b0; clear_error = 1'b0;
        almost_full = '0; full = '0; empty = 5'h1F; almost_empty = '0;

        //    tag        rst   ini   clr   af     full   empty  expected state
        step("rst0",     1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 5'h1F, S_INIT);
        step("rst1",     1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 5'h1F, S_INIT);
        step("start",    1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 5'h1F, S_IDLE);
        step("idle",     1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h1F, S_IDLE);
        step("act",      1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_ACT);
        step("act_hold", 1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_ACT);
        step("pause1",   1'b1, 1'b0, 1'b0, 5'h02, 5'h00, 5'h00, S_PAUSE);
        step("minhold",  1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_PAUSE);
        step("resume1",  1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_ACT);
        step("pc_af05",  1'b1, 1'b0, 1'b0, 5'h05, 5'h00, 5'h00, S_PAUSE);
        step("pc_af10",  1'b1, 1'b0, 1'b0, 5'h10, 5'h00, 5'h00, S_PAUSE);
        step("af_stays", 1'b1, 1'b0, 1'b0, 5'h10, 5'h00, 5'h00, S_PAUSE);
        step("resume2",  1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_ACT);
        step("pause3",   1'b1, 1'b0, 1'b0, 5'h02, 5'h00, 5'h00, S_PAUSE);
        step("ovf",      1'b1, 1'b0, 1'b0, 5'h02, 5'h10, 5'h00, S_ERR);
        for (int i = 0; i < 10; i++)
            step("err_hold", 1'b1, 1'b1, 1'b0, 5'h03, 5'h10, 5'h00, S_ERR);
        step("clr_full", 1'b1, 1'b0, 1'b1, 5'h00, 5'h10, 5'h00, S_INIT);
        step("init_f",   1'b1, 1'b0, 1'b0, 5'h00, 5'h10, 5'h00, S_INIT);
        step("restart",  1'b1, 1'b1, 1'b0, 5'h00, 5'h10, 5'h00, S_IDLE);
        step("idle_ovf", 1'b1, 1'b0, 1'b0, 5'h00, 5'h08, 5'h00, S_ERR);
        step("clr",      1'b1, 1'b0, 1'b1, 5'h00, 5'h00, 5'h00, S_INIT);
        step("start2",   1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 5'h00, S_IDLE);
        step("act2",     1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_ACT);
        step("pause4",   1'b1, 1'b0, 1'b0, 5'h01, 5'h00, 5'h00, S_PAUSE);
        step("hold4",    1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_PAUSE);
        step("resume4",  1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, S_ACT);
        step("pause5",   1'b1, 1'b0, 1'b0, 5'h01, 5'h00, 5'h00, S_PAUSE);
        step("mid_rst",  1'b0, 1'b1, 1'b0, 5'h01, 5'h00, 5'h00, S_INIT);
        step("start3",   1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 5'h1F, S_IDLE);
        step("idle3",    1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h1F, S_IDLE);
        step("act3",     1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h0F, S_ACT);
        step("drain",    1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h1F, S_IDLE);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
